// File: rtl/control_pkg.sv
// Shared encodings for the RV32I main decoder: opcodes, ALU-operation classes
// and the packed control bundle carried from decode to the output register.
package control_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_BR    = 3'b001,
    ALUOP_R     = 3'b010,
    ALUOP_I     = 3'b011,
    ALUOP_JALR  = 3'b100,
    ALUOP_LUI   = 3'b101,
    ALUOP_AUIPC = 3'b110,
    ALUOP_JAL   = 3'b111
  } aluop_e;

  typedef struct packed {
    logic   branch;
    logic   memread;
    logic   memtoreg;
    aluop_e aluop;
    logic   memwrite;
    logic   alusrc;
    logic   regwrite;
  } ctrl_t;

  // Argument order matches the decode table so each row reads like the table.
  function automatic ctrl_t make_ctrl(
    input logic   branch,
    input logic   memread,
    input logic   memtoreg,
    input aluop_e aluop,
    input logic   memwrite,
    input logic   alusrc,
    input logic   regwrite
  );
    ctrl_t c;
    c.branch   = branch;
    c.memread  = memread;
    c.memtoreg = memtoreg;
    c.aluop    = aluop;
    c.memwrite = memwrite;
    c.alusrc   = alusrc;
    c.regwrite = regwrite;
    return c;
  endfunction

  localparam ctrl_t CTRL_NOP = '{
    branch: 1'b0, memread: 1'b0, memtoreg: 1'b0, aluop: ALUOP_ADD,
    memwrite: 1'b0, alusrc: 1'b0, regwrite: 1'b0
  };

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-control-bundle mapping. The o_illegal flag exists
// only when CONTROL_ILLEGAL_EN is defined.
module control_decode
  import control_pkg::*;
(
  input  logic [6:0] i_opcode,
`ifdef CONTROL_ILLEGAL_EN
  output logic       o_illegal,
`endif
  output ctrl_t      o_ctrl
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    o_ctrl = CTRL_NOP;
`ifdef CONTROL_ILLEGAL_EN
    o_illegal = 1'b0;
`endif
    case (i_opcode)
      OP_RTYPE:  o_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, ALUOP_R,     1'b0, 1'b0, 1'b1);
      OP_IMM:    o_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, ALUOP_I,     1'b0, 1'b1, 1'b1);
      OP_LOAD:   o_ctrl = make_ctrl(1'b0, 1'b1, 1'b1, ALUOP_ADD,   1'b0, 1'b1, 1'b1);
      OP_STORE:  o_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, ALUOP_ADD,   1'b1, 1'b1, 1'b0);
      OP_BRANCH: o_ctrl = make_ctrl(1'b1, 1'b0, 1'b0, ALUOP_BR,    1'b0, 1'b0, 1'b0);
      OP_JALR:   o_ctrl = make_ctrl(1'b1, 1'b0, 1'b0, ALUOP_JALR,  1'b0, 1'b1, 1'b1);
      OP_JAL:    o_ctrl = make_ctrl(1'b1, 1'b0, 1'b0, ALUOP_JAL,   1'b0, 1'b0, 1'b1);
      OP_LUI:    o_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, ALUOP_LUI,   1'b0, 1'b1, 1'b1);
      OP_AUIPC:  o_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, ALUOP_AUIPC, 1'b0, 1'b1, 1'b1);
      default: begin
        o_ctrl = CTRL_NOP;
`ifdef CONTROL_ILLEGAL_EN
        o_illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I main decoder with a one-cycle registered output stage.
// Define CONTROL_ILLEGAL_EN to add the registered 'illegal' output.
module control_unit
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic        branch,
  output logic        memread,
  output logic        memtoreg,
  output logic [2:0]  aluop,
  output logic        memwrite,
  output logic        alusrc,
  output logic        regwrite
`ifdef CONTROL_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  ctrl_t r_ctrl;
  ctrl_t w_ctrl;
  logic  w_unused_upper;

  // Only the opcode field steers the control strobes.
  assign w_unused_upper = ^instruction[31:7];

`ifdef CONTROL_ILLEGAL_EN
  logic w_illegal;
  logic r_illegal;

  control_decode u_decode (
    .i_opcode  (instruction[6:0]),
    .o_illegal (w_illegal),
    .o_ctrl    (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) r_illegal <= 1'b0;
    else     r_illegal <= w_illegal;
  end

  assign illegal = r_illegal;
`else
  control_decode u_decode (
    .i_opcode (instruction[6:0]),
    .o_ctrl   (w_ctrl)
  );
`endif

  // NOTE: reset is sampled on the clock edge and takes priority over that
  // edge's decode; state uses non-blocking assignments so all outputs move
  // together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) r_ctrl <= CTRL_NOP;
    else     r_ctrl <= w_ctrl;
  end

  assign branch   = r_ctrl.branch;
  assign memread  = r_ctrl.memread;
  assign memtoreg = r_ctrl.memtoreg;
  assign aluop    = r_ctrl.aluop;
  assign memwrite = r_ctrl.memwrite;
  assign alusrc   = r_ctrl.alusrc;
  assign regwrite = r_ctrl.regwrite;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed plan plus randomized traffic
// checked against a table-driven reference model.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        branch, memread, memtoreg, memwrite, alusrc, regwrite;
  logic [2:0]  aluop;
`ifdef CONTROL_ILLEGAL_EN
  logic        illegal;
`endif

  control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .branch      (branch),
    .memread     (memread),
    .memtoreg    (memtoreg),
    .aluop       (aluop),
    .memwrite    (memwrite),
    .alusrc      (alusrc),
    .regwrite    (regwrite)
`ifdef CONTROL_ILLEGAL_EN
    ,
    .illegal     (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [8:0] bundle;   // {branch, memread, memtoreg, aluop, memwrite, alusrc, regwrite}
    bit       ill;
    string    tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  // Operation table, one row per opcode, outputs in table order.
  bit [6:0] op_tab [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1100111, 7'b1101111, 7'b0110111,
                           7'b0010111};
  bit [8:0] out_tab [9] = '{9'b0_0_0_010_0_0_1, 9'b0_0_0_011_0_1_1,
                            9'b0_1_1_000_0_1_1, 9'b0_0_0_000_1_1_0,
                            9'b1_0_0_001_0_0_0, 9'b1_0_0_100_0_1_1,
                            9'b1_0_0_111_0_0_1, 9'b0_0_0_101_0_1_1,
                            9'b0_0_0_110_0_1_1};

  function automatic exp_t model(input bit r, input bit [31:0] instr, input string tag);
    exp_t e;
    e.bundle = '0;
    e.ill    = 1'b0;
    e.tag    = tag;
    if (!r) begin
      e.ill = 1'b1;
      foreach (op_tab[k]) begin
        if (op_tab[k] == instr[6:0]) begin
          e.bundle = out_tab[k];
          e.ill    = 1'b0;
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus away from the sampling edge and log its expectation.
  task automatic step(input bit r, input bit [31:0] instr, input string tag);
    @(negedge clk);
    rst         = r;
    instruction = instr;
    exp_q.push_back(model(r, instr, tag));
  endtask

  // Monitor: every cycle after an issued stimulus produces one output word.
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {branch, memread, memtoreg, aluop, memwrite, alusrc, regwrite};
        check(e.tag, {7'd0, act}, {7'd0, e.bundle});
`ifdef CONTROL_ILLEGAL_EN
        check({e.tag, "_illegal"}, {15'd0, illegal}, {15'd0, e.ill});
`endif
        check({e.tag, "_rw_excl"}, {15'd0, memread & memwrite}, 16'd0);
        check({e.tag, "_m2r_rd"}, {15'd0, memtoreg & ~memread}, 16'd0);
      end
    end
  end

  initial begin
    bit [31:0] instr;
    int        wait_cycles;
    rst         = 1'b1;
    instruction = 32'h0000_0033;

    step(1, 32'h0000_0033, "reset0");
    step(1, 32'h0000_0033, "reset1");
    step(0, 32'h0000_0033, "rtype");
    step(0, 32'h0000_0013, "itype");
    step(0, 32'h0000_0003, "load");
    step(0, 32'h0000_0023, "store");
    step(0, 32'h0000_0067, "jalr");
    step(0, 32'h0000_0063, "branch");
    step(0, 32'h0000_006F, "jal");
    step(0, 32'h0000_0037, "lui");
    step(0, 32'h0000_0017, "auipc");
    step(0, 32'hFFFF_F003, "load_upper");
    step(0, 32'h0000_007F, "unknown");
    step(0, 32'h0000_0033, "after_unknown");
    step(0, 32'h0000_0003, "pre_rst");
    step(1, 32'h0000_0023, "store_in_rst");
    step(0, 32'h0000_0023, "store_resume");

    for (int i = 0; i < 400; i++) begin
      instr = $urandom;
      if ($urandom_range(0, 9) < 7) instr[6:0] = op_tab[$urandom_range(0, 8)];
      step(($urandom_range(0, 15) == 0), instr, "random");
    end

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
